ph_frame_streamer: RTL and testbench

- Transmit side of the pulse-height ping-pong cache.
- Once the writer has filled one of the two PH buffers, this block reads that buffer back through a BRAM read port.
- It emits the buffer contents as an AXI4-Stream master frame with tlast on the final word, then hands the buffer back to the writer.
- It sits between the PH cache BRAMs and the packetiser/DMA stream path.

---
 rtl/ph_frame_streamer.sv | 184 ++++++++++++++++++
 tb/tb_ph_frame_streamer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ph_frame_streamer.sv
// Reads a filled PH ping-pong buffer over BRAM and streams it out as one AXI4-Stream frame.
// Define PH_STREAMER_BL_SUB_EN to subtract the baseline from the low half-word of every sample.
module ph_frame_streamer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done,
    input  logic              frame_buf,
    input  logic [ADDR_W:0]   frame_len,
    output logic              rd_en,
    output logic              rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] bl_data,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              buf_release,
    output logic              rel_buf,
    output logic              busy,
    output logic [15:0]       ovf_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_RELEASE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sel;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic              r_inflight;
    logic              r_infl_last;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_cnt;
    logic              r_pend_v;
    logic              r_pend_buf;
    logic [ADDR_W:0]   r_pend_len;
    logic [15:0]       r_ovf;

    logic              w_pop;
    logic              w_rd_en;
    logic              w_rd_last;
    logic              w_start;
    logic              w_start_buf;
    logic [ADDR_W:0]   w_start_len;
    logic [2:0]        w_occ;
    logic [DATA_W-1:0] w_wdata;
    logic              w_unused_bl;

    // Occupancy counts the word leaving this cycle as gone, so reads keep
    // issuing back-to-back while the sink accepts every cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_buf = r_pend_v ? r_pend_buf : frame_buf;
        w_start_len = r_pend_v ? r_pend_len : frame_len;
        w_pop       = (r_cnt != 2'd0) && m_axis_tready;
        w_occ       = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);
        w_rd_en     = 1'b0;
        w_rd_last   = (r_issued == r_len - (ADDR_W+1)'(1));
        unique case (r_state)
            S_IDLE: begin
                if (r_pend_v || frame_done) begin
                    w_start     = 1'b1;
                    w_state_nxt = (w_start_len == '0) ? S_RELEASE : S_STREAM;
                end
            end
            S_STREAM: begin
                w_rd_en = (r_issued < r_len) && (w_occ < 3'(FIFO_DEPTH));
                if (w_pop && r_fifo_last[r_rp]) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

`ifdef PH_STREAMER_BL_SUB_EN
    always_comb begin
        w_wdata       = rd_data;
        w_wdata[15:0] = (rd_data[15:0] >= bl_data[15:0]) ?
                        (rd_data[15:0] - bl_data[15:0]) : 16'd0;
    end
    assign w_unused_bl = ^bl_data[DATA_W-1:16];
`else
    assign w_wdata     = rd_data;
    assign w_unused_bl = ^bl_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel          <= 1'b0;
            r_len          <= '0;
            r_issued       <= '0;
            r_inflight     <= 1'b0;
            r_infl_last    <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wp           <= 1'b0;
            r_rp           <= 1'b0;
            r_cnt          <= '0;
        end else begin
            if (w_start) begin
                r_sel    <= w_start_buf;
                r_len    <= w_start_len;
                r_issued <= '0;
            end else begin
                r_issued <= r_issued + (ADDR_W+1)'(w_rd_en);
            end
            r_inflight  <= w_rd_en;
            r_infl_last <= w_rd_en && w_rd_last;
            if (r_inflight) begin
                r_fifo_data[r_wp] <= w_wdata;
                r_fifo_last[r_wp] <= r_infl_last;
                r_wp              <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
        end
    end

    // In IDLE a waiting slot is always served first; a pulse arriving in
    // that same cycle refills the slot instead of being dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_v   <= 1'b0;
            r_pend_buf <= 1'b0;
            r_pend_len <= '0;
            r_ovf      <= '0;
        end else if (r_state == S_IDLE) begin
            if (r_pend_v) begin
                if (frame_done) begin
                    r_pend_buf <= frame_buf;
                    r_pend_len <= frame_len;
                end else begin
                    r_pend_v <= 1'b0;
                end
            end
        end else if (frame_done) begin
            if (!r_pend_v) begin
                r_pend_v   <= 1'b1;
                r_pend_buf <= frame_buf;
                r_pend_len <= frame_len;
            end else if (r_ovf != 16'hFFFF) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    assign rd_en         = w_rd_en;
    assign rd_sel        = r_sel;
    assign rd_addr       = w_rd_en ? r_issued[ADDR_W-1:0] : '0;
    assign m_axis_tvalid = (r_cnt != 2'd0);
    assign m_axis_tdata  = r_fifo_data[r_rp];
    assign m_axis_tlast  = m_axis_tvalid && r_fifo_last[r_rp];
    assign buf_release   = (r_state == S_RELEASE);
    assign rel_buf       = buf_release && r_sel;
    assign busy          = (r_state != S_IDLE);
    assign ovf_cnt       = r_ovf;

endmodule

// File: tb/tb_ph_frame_streamer.sv
// Directed bench for ph_frame_streamer with a 1-cycle-latency BRAM model.
// Expected words follow the optional PH_STREAMER_BL_SUB_EN build when it is defined.
module tb_ph_frame_streamer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_done = 1'b0;
    logic              frame_buf = 1'b0;
    logic [ADDR_W:0]   frame_len = '0;
    logic              rd_en;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] bl_data = '0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b0;
    logic              buf_release;
    logic              rel_buf;
    logic              busy;
    logic [15:0]       ovf_cnt;

    logic [31:0] mem_base [2];
    logic [15:0] bl_val = 16'h0030;
    int npass = 0;
    int nfail = 0;

    ph_frame_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .frame_done(frame_done), .frame_buf(frame_buf), .frame_len(frame_len),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data), .bl_data(bl_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .buf_release(buf_release), .rel_buf(rel_buf),
        .busy(busy), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // BRAM: word n of buffer b is mem_base[b] + n; baseline upper half is junk.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_base[rd_sel] + 32'(rd_addr);
            bl_data <= {16'hABCD, bl_val};
        end
    end

    function automatic logic [31:0] expw(input logic [31:0] raw);
`ifdef PH_STREAMER_BL_SUB_EN
        return {raw[31:16], (raw[15:0] >= bl_val) ? raw[15:0] - bl_val : 16'h0};
`else
        return raw;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert (got === exp) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic b, input logic [ADDR_W:0] l);
        frame_done = 1'b1;
        frame_buf  = b;
        frame_len  = l;
        tick();
        frame_done = 1'b0;
    endtask

    // Drains one frame; returns one cycle after its buf_release.
    task automatic run_frame(input int len, input logic sel, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit rel = 0;
        bit stall = 0;
        logic [31:0] pd = '0;
        while (!rel && cyc < 2000) begin
            m_axis_tready = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            #1;
            if (stall) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, pd);
            end
            if (rd_en) begin
                chk("rd_sel", rd_sel, sel);
                chk("rd_addr_bound", rd_addr < len, 1);
            end
            if (buf_release) begin
                chk("rel_buf", rel_buf, sel);
                chk("word_count", k, len);
                rel = 1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                chk("tdata", m_axis_tdata, expw(mem_base[sel] + 32'(k)));
                chk("tlast", m_axis_tlast, k == len - 1);
                k++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            tick();
            cyc++;
        end
        chk("release_seen", rel, 1);
        chk("release_once", buf_release, 0);
        m_axis_tready = 1'b0;
    endtask

    initial begin
        bit found;
        mem_base[0] = 32'h0000_0100;
        mem_base[1] = 32'h1000_0000;

        repeat (3) tick();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_release", buf_release, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_ovf", ovf_cnt, 0);
        rst = 1'b0;
        tick();

        // Exact timing, tready held high.
        m_axis_tready = 1'b1;
        pulse(1'b0, 9'd4);
        chk("t1_rd_en0", rd_en, 1);
        chk("t1_addr0", rd_addr, 0);
        chk("t1_busy", busy, 1);
        chk("t1_tvalid_early", m_axis_tvalid, 0);
        tick();
        chk("t1_tvalid_e1", m_axis_tvalid, 0);
        chk("t1_addr1", rd_addr, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_tvalid", m_axis_tvalid, 1);
            chk("t1_tdata", m_axis_tdata, expw(32'h100 + 32'(k)));
            chk("t1_tlast", m_axis_tlast, k == 3);
            chk("t1_no_rel", buf_release, 0);
        end
        tick();
        chk("t1_release", buf_release, 1);
        chk("t1_rel_buf", rel_buf, 0);
        chk("t1_tvalid_after", m_axis_tvalid, 0);
        tick();
        chk("t1_rel_done", buf_release, 0);
        chk("t1_idle", busy, 0);
        m_axis_tready = 1'b0;

        // Backpressure with tready 1,0,0,1...
        pulse(1'b0, 9'd4);
        run_frame(4, 1'b0, 1'b1);

        // Pending slot plus one dropped pulse.
        pulse(1'b0, 9'd4);
        pulse(1'b1, 9'd256);
        pulse(1'b0, 9'd3);
        chk("t3_ovf", ovf_cnt, 1);
        run_frame(4, 1'b0, 1'b1);
        run_frame(256, 1'b1, 1'b0);
        chk("t3_ovf_after", ovf_cnt, 1);
        chk("t3_idle", busy, 0);

        // Zero-length frame.
        pulse(1'b1, 9'd0);
        chk("t4_release", buf_release, 1);
        chk("t4_rel_buf", rel_buf, 1);
        chk("t4_no_tvalid", m_axis_tvalid, 0);
        chk("t4_no_rd", rd_en, 0);
        tick();
        chk("t4_rel_done", buf_release, 0);
        chk("t4_idle", busy, 0);

        // Asynchronous reset while word 2 of 8 is presented.
        m_axis_tready = 1'b1;
        pulse(1'b0, 9'd8);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_axis_tvalid && m_axis_tdata === expw(32'h102)) found = 1;
            else tick();
        end
        chk("t5_word2_seen", found, 1);
        rst = 1'b1;
        #1;
        chk("t5_tvalid", m_axis_tvalid, 0);
        chk("t5_tlast", m_axis_tlast, 0);
        chk("t5_tdata", m_axis_tdata, 0);
        chk("t5_rd_en", rd_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ovf", ovf_cnt, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_rel", buf_release, 0);
            chk("t5_no_tvalid", m_axis_tvalid, 0);
        end
        m_axis_tready = 1'b0;
        pulse(1'b0, 9'd4);
        run_frame(4, 1'b0, 1'b0);

        // Baseline subtraction on a single-word frame.
        mem_base[0] = 32'h0005_0010;
        bl_val = 16'h0004;
        pulse(1'b0, 9'd1);
        tick();
        tick();
        chk("bl_tvalid", m_axis_tvalid, 1);
        chk("bl_tlast", m_axis_tlast, 1);
`ifdef PH_STREAMER_BL_SUB_EN
        chk("bl_sub", m_axis_tdata, 32'h0005_000C);
`else
        chk("bl_pass", m_axis_tdata, 32'h0005_0010);
`endif
        m_axis_tready = 1'b1;
        tick();
        chk("bl_release", buf_release, 1);
        m_axis_tready = 1'b0;
        tick();
        bl_val = 16'h0020;
        pulse(1'b0, 9'd1);
        tick();
        tick();
        chk("bl2_tvalid", m_axis_tvalid, 1);
`ifdef PH_STREAMER_BL_SUB_EN
        chk("bl_clamp", m_axis_tdata, 32'h0005_0000);
`else
        chk("bl2_pass", m_axis_tdata, 32'h0005_0010);
`endif
        m_axis_tready = 1'b1;
        tick();
        chk("bl2_release", buf_release, 1);
        tick();
        chk("bl2_idle", busy, 0);

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
